// File: rtl/machine_cycle_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// machine_cycle_sequencer_pkg
//   Shared definitions for the MCU51 machine-cycle sequencer.
//   - Tick constants for the 12-tick machine cycle.
//     S1P1 is tick 0 and S6P2 is tick 11.
//   - ALE strobe window constants.
//   - PSEN window length.
//   - Idle/run FSM state type.
//   Optional macro DOUBLE_ALE_EN adds the tick window for the second ALE pulse.
// -----------------------------------------------------------------------------
package machine_cycle_sequencer_pkg;

  localparam int TICK_W = 4;

  // First and last tick of a machine cycle.
  localparam logic [TICK_W-1:0] TICK_S1P1 = 4'd0;
  localparam logic [TICK_W-1:0] TICK_S6P2 = 4'd11;

  // Primary ALE pulse: S1P2..S2P1.
  localparam logic [TICK_W-1:0] ALE_FIRST = 4'd1;
  localparam logic [TICK_W-1:0] ALE_LAST  = 4'd2;

`ifdef DOUBLE_ALE_EN
  // Second ALE pulse: S4P2..S5P1.
  localparam logic [TICK_W-1:0] ALE2_FIRST = 4'd7;
  localparam logic [TICK_W-1:0] ALE2_LAST  = 4'd8;
`endif

  // PSEN stays low for this many ticks, starting at PSEN_LO.
  localparam int PSEN_WIN = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_e;

endpackage

// File: rtl/machine_cycle_sequencer_mcycle_counter.sv
// -----------------------------------------------------------------------------
// machine_cycle_sequencer_mcycle_counter
//   Tracks which machine cycle of the current instruction is executing.
//   Latches the instruction length and produces the boundary decision.
// Ports
//   clk         in  core clock, rising edge
//   reset       in  asynchronous active-low reset
//   mc_end      in  machine-cycle end: tick 11, running, not held
//   len_latch   in  tick 11 while running; the length is sampled here in mcycle 0
//   cycles      in  instruction length minus 1
//   mcycle      out index of the current machine cycle
//   instr_last  out current machine cycle is the instruction's final one
//   boundary    out mc_end of the final machine cycle, so the next tick 0 starts
//                   an instruction
// -----------------------------------------------------------------------------
module machine_cycle_sequencer_mcycle_counter
  import machine_cycle_sequencer_pkg::*;
#(
  parameter int CYC_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mc_end,
  input  logic             len_latch,
  input  logic [CYC_W-1:0] cycles,
  output logic [CYC_W-1:0] mcycle,
  output logic             instr_last,
  output logic             boundary
);

  logic [CYC_W-1:0] mcycle_q, mcycle_d;
  logic [CYC_W-1:0] cyc_len_q, cyc_len_d;
  logic             last_w;

  // In mcycle 0 the length has not been latched yet, so decide from the live
  // input. Later cycles compare against the latched copy.
  assign last_w = (mcycle_q == '0) ? (cycles == '0) : (mcycle_q == cyc_len_q);

  always_comb begin
    mcycle_d  = mcycle_q;
    cyc_len_d = cyc_len_q;
    if (len_latch && (mcycle_q == '0)) begin
      cyc_len_d = cycles;
    end
    if (mc_end) begin
      mcycle_d = last_w ? '0 : (mcycle_q + CYC_W'(1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcycle_q  <= '0;
      cyc_len_q <= '0;
    end else begin
      mcycle_q  <= mcycle_d;
      cyc_len_q <= cyc_len_d;
    end
  end

  assign mcycle     = mcycle_q;
  assign instr_last = last_w;
  assign boundary   = mc_end && last_w;

endmodule

// File: rtl/machine_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// machine_cycle_sequencer
//   Timing generator for the MCU51 core.
//   Divides clk into 12-tick machine cycles (S1P1..S6P2).
//   Counts machine cycles per instruction and produces the strobes used by the
//   control unit.
//   Supports wait states at tick 11 (hold) and idle/run control at instruction
//   boundaries.
// Parameters
//   CYC_W        width of the machine-cycle count
//   PSEN_LO      first tick of the 4-tick PSEN-low window; must be >= 1
// Ports
//   clk          core clock, rising edge
//   reset        asynchronous active-low reset
//   run          1 = sequence; only sampled at an instruction boundary
//   hold         wait-state request, sampled at tick 11
//   ext_fetch    external code fetch this machine cycle, sampled at tick 0
//   cycles       instruction length minus 1
//   state        S-state 1..6
//   Phase        0 = P1, 1 = P2
//   ALE          address latch enable (registered)
//   PSEN         program store enable, active low (registered)
//   mc_start     tick 0 of every machine cycle
//   mc_end       tick 11 while not held
//   instr_start  tick 0 of mcycle 0
//   instr_last   final machine cycle of the instruction
//   mcycle       machine-cycle index within the instruction
// Configuration
//   DOUBLE_ALE_EN  when defined, ALE also pulses at ticks 7-8.
// -----------------------------------------------------------------------------
module machine_cycle_sequencer
  import machine_cycle_sequencer_pkg::*;
#(
  parameter int CYC_W   = 2,
  parameter int PSEN_LO = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             hold,
  input  logic             ext_fetch,
  input  logic [CYC_W-1:0] cycles,
  output logic [2:0]       state,
  output logic             Phase,
  output logic             ALE,
  output logic             PSEN,
  output logic             mc_start,
  output logic             mc_end,
  output logic             instr_start,
  output logic             instr_last,
  output logic [CYC_W-1:0] mcycle
);

  localparam logic [TICK_W-1:0] PSEN_FIRST = TICK_W'(PSEN_LO);
  localparam logic [TICK_W-1:0] PSEN_LAST  = TICK_W'(PSEN_LO + PSEN_WIN - 1);

  seq_state_e        fsm_q, fsm_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              fetch_q, fetch_d;
  logic              ale_q, ale_d;
  logic              psen_q, psen_d;

  logic              running;
  logic              running_d;
  logic              end_tick;
  logic              mc_end_w;
  logic              boundary;
  logic              last_w;
  logic              ale_win;
  logic              psen_win;

  assign running  = (fsm_q != ST_IDLE);
  assign end_tick = running && (tick_q == TICK_S6P2);
  assign mc_end_w = end_tick && !hold;

  machine_cycle_sequencer_mcycle_counter #(
    .CYC_W (CYC_W)
  ) u_mcycle_counter (
    .clk        (clk),
    .reset      (reset),
    .mc_end     (mc_end_w),
    .len_latch  (end_tick),
    .cycles     (cycles),
    .mcycle     (mcycle),
    .instr_last (last_w),
    .boundary   (boundary)
  );

  // Next-state logic for the idle/run FSM and the tick counter.
  always_comb begin
    fsm_d   = fsm_q;
    tick_d  = tick_q;
    fetch_d = fetch_q;
    case (fsm_q)
      ST_IDLE: begin
        tick_d = TICK_S1P1;
        if (run) begin
          fsm_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick_q == TICK_S1P1) begin
          fetch_d = ext_fetch;
        end
        if (tick_q != TICK_S6P2) begin
          tick_d = tick_q + TICK_W'(1);
        end else if (hold) begin
          fsm_d = ST_HOLD;
        end else begin
          tick_d = TICK_S1P1;
          if (boundary && !run) begin
            fsm_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        // Tick stays at 11 until hold drops. The release cycle is the real
        // mc_end, so the boundary decision is made here as well.
        if (!hold) begin
          tick_d = TICK_S1P1;
          fsm_d  = (boundary && !run) ? ST_IDLE : ST_RUN;
        end
      end
      default: begin
        fsm_d  = ST_IDLE;
        tick_d = TICK_S1P1;
      end
    endcase
  end

  // Strobes are computed from the next tick and registered. The outputs
  // therefore line up with tick_q and are glitch-free.
  assign running_d = (fsm_d != ST_IDLE);

  always_comb begin
    ale_win = (tick_d >= ALE_FIRST) && (tick_d <= ALE_LAST);
`ifdef DOUBLE_ALE_EN
    ale_win = ale_win || ((tick_d >= ALE2_FIRST) && (tick_d <= ALE2_LAST));
`endif
    psen_win = (tick_d >= PSEN_FIRST) && (tick_d <= PSEN_LAST);
    ale_d    = running_d && ale_win;
    psen_d   = !(running_d && fetch_d && psen_win);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q   <= ST_IDLE;
      tick_q  <= TICK_S1P1;
      fetch_q <= 1'b0;
      ale_q   <= 1'b0;
      psen_q  <= 1'b1;
    end else begin
      fsm_q   <= fsm_d;
      tick_q  <= tick_d;
      fetch_q <= fetch_d;
      ale_q   <= ale_d;
      psen_q  <= psen_d;
    end
  end

  assign state       = tick_q[3:1] + 3'd1;
  assign Phase       = tick_q[0];
  assign ALE         = ale_q;
  assign PSEN        = psen_q;
  assign mc_start    = running && (tick_q == TICK_S1P1);
  assign mc_end      = mc_end_w;
  assign instr_start = mc_start && (mcycle == '0);
  assign instr_last  = running && last_w;

endmodule

// File: tb/tb_machine_cycle_sequencer.sv
module tb_machine_cycle_sequencer;

  localparam int CYC_W = 2;
`ifdef DOUBLE_ALE_EN
  localparam int ALE_PER_MC = 4;
`else
  localparam int ALE_PER_MC = 2;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             run;
  logic             hold;
  logic             ext_fetch;
  logic [CYC_W-1:0] cycles;
  logic [2:0]       state;
  logic             Phase;
  logic             ALE;
  logic             PSEN;
  logic             mc_start;
  logic             mc_end;
  logic             instr_start;
  logic             instr_last;
  logic [CYC_W-1:0] mcycle;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  machine_cycle_sequencer #(
    .CYC_W   (CYC_W),
    .PSEN_LO (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .hold        (hold),
    .ext_fetch   (ext_fetch),
    .cycles      (cycles),
    .state       (state),
    .Phase       (Phase),
    .ALE         (ALE),
    .PSEN        (PSEN),
    .mc_start    (mc_start),
    .mc_end      (mc_end),
    .instr_start (instr_start),
    .instr_last  (instr_last),
    .mcycle      (mcycle)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int tick;
    int mc;
    int len;
    bit running;
    bit fetch;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.tick = 0; r.mc = 0; r.len = 0; r.running = 1'b0; r.fetch = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(model_t s, bit run_v, bit hold_v, bit fetch_v, int cyc_v);
    model_t n;
    bit     last;
    n = s;
    if (!s.running) begin
      n.tick = 0;
      if (run_v) n.running = 1'b1;
    end else begin
      if (s.tick == 0) n.fetch = fetch_v;
      if (s.tick == 11 && s.mc == 0) n.len = cyc_v;
      if (s.tick < 11) begin
        n.tick = s.tick + 1;
      end else if (!hold_v) begin
        last   = (s.mc == 0) ? (cyc_v == 0) : (s.mc == s.len);
        n.tick = 0;
        if (last) begin
          n.mc = 0;
          if (!run_v) n.running = 1'b0;
        end else begin
          n.mc = s.mc + 1;
        end
      end
    end
    return n;
  endfunction

  initial begin
    m = model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m = model_reset();
      else        m = model_step(m, run, hold, ext_fetch, int'(cycles));
    end
  end

  task automatic check(string name, int actual, int required);
    n_checks++;
    if (actual != required) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t",
               name, actual, actual, required, required, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic compare_outputs();
    logic [11:0] got;
    logic [11:0] exp;
    bit e_ale, e_psen, e_mcs, e_mce, e_is, e_il;
    int e_state;
    e_state = m.tick / 2 + 1;
    e_ale   = m.running && (m.tick == 1 || m.tick == 2);
`ifdef DOUBLE_ALE_EN
    e_ale   = e_ale || (m.running && (m.tick == 7 || m.tick == 8));
`endif
    e_psen  = !(m.running && m.fetch && m.tick >= 6 && m.tick <= 9);
    e_mcs   = m.running && m.tick == 0;
    e_mce   = m.running && m.tick == 11 && !hold;
    e_is    = e_mcs && m.mc == 0;
    e_il    = m.running && ((m.mc == 0) ? (cycles == 0) : (m.mc == m.len));
    got = {state, Phase, ALE, PSEN, mc_start, mc_end, instr_start, instr_last, mcycle};
    exp = {3'(e_state), 1'(m.tick % 2), e_ale, e_psen, e_mcs, e_mce, e_is, e_il, CYC_W'(m.mc)};
    check("outputs{st,ph,ale,psen,mcs,mce,is,il,mcy}", int'(got), int'(exp));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) compare_outputs();
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt_a, cnt_b, cnt_c, cnt_d, idx_a, idx_b, idx_c;
    bit found;

    reset = 1'b0; run = 1'b0; hold = 1'b0; ext_fetch = 1'b0; cycles = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check_en = 1'b1;

    // 1: idle after reset
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ALE || !PSEN || mc_start || mc_end || instr_start || state != 3'd1) cnt_a++;
    end
    check("idle_activity", cnt_a, 0);
    check("idle_state", int'(state), 1);
    check("idle_psen", int'(PSEN), 1);
    $display("phase idle: done at %0t", $time);

    // 2: single-cycle instructions with external fetch
    @(posedge clk);
    #1 run = 1'b1; cycles = 2'd0; ext_fetch = 1'b1;
    @(posedge clk);
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; idx_a = -1; idx_b = -1; idx_c = -1;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (mc_start) begin
        cnt_a++;
        if (idx_a >= 0 && idx_b < 0) idx_b = i;
        if (idx_a < 0) idx_a = i;
      end
      if (ALE) cnt_b++;
      if (!PSEN) begin
        cnt_c++;
        if (idx_c < 0) idx_c = i;
      end
      if (instr_start) cnt_d++;
    end
    check("t2_mc_start_count", cnt_a, 3);
    check("t2_mc_start_gap", idx_b - idx_a, 12);
    check("t2_ale_cycles", cnt_b, 3 * ALE_PER_MC);
    check("t2_psen_low_cycles", cnt_c, 12);
    check("t2_psen_first_tick", idx_c, 6);
    check("t2_instr_start_count", cnt_d, 3);
    $display("phase single-cycle: done at %0t", $time);

    // 3: two-cycle instructions
    @(posedge clk);
    #1 cycles = 2'd1;
    cnt_a = 0; cnt_b = 0; idx_a = -1; idx_b = -1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (instr_start) begin
        cnt_a++;
        if (idx_a >= 0 && idx_b < 0) idx_b = i;
        if (idx_a < 0) idx_a = i;
      end
      if (instr_last) cnt_b++;
    end
    check("t3_instr_start_count", cnt_a, 2);
    check("t3_instr_start_gap", idx_b - idx_a, 24);
    check("t3_instr_last_cycles", cnt_b, 24);
    $display("phase two-cycle: done at %0t", $time);

    // 4: wait state of 5 clocks at tick 11
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (m.running && m.tick == 10) found = 1'b1;
    end
    check("t4_reach_tick10", int'(found), 1);
    @(posedge clk);
    #1 hold = 1'b1;
    cnt_a = 0; idx_a = -1; idx_b = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mc_end) begin
        cnt_a++;
        if (idx_b < 0) idx_b = i;
      end
      if (mc_start && idx_a < 0) idx_a = i;
      if (i < 5) begin
        @(posedge clk);
        #1 if (i == 4) hold = 1'b0;
      end else begin
        @(posedge clk);
      end
    end
    check("t4_mc_end_count", cnt_a, 1);
    check("t4_mc_end_index", idx_b, 5);
    check("t4_next_mc_start_index", idx_a, 6);
    $display("phase hold: done at %0t", $time);

    // 5: run dropped at tick 3 of mcycle 0 of a two-cycle instruction
    #1 cycles = 2'd1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (m.running && m.mc == 0 && m.tick == 2) found = 1'b1;
    end
    check("t5_reach_tick2", int'(found), 1);
    @(posedge clk);
    #1 run = 1'b0;
    cnt_a = 0; cnt_b = 0; idx_a = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mc_start) cnt_a++;
      if (instr_last) cnt_b++;
      if (idx_a < 0 && state == 3'd1 && !Phase && !mc_start) idx_a = i;
    end
    check("t5_mc_start_count", cnt_a, 1);
    check("t5_instr_last_cycles", cnt_b, 12);
    check("t5_idle_index", idx_a, 21);
    $display("phase run-drop: done at %0t", $time);

    // 6: asynchronous reset at tick 7 with PSEN low
    @(posedge clk);
    #1 run = 1'b1; ext_fetch = 1'b1; cycles = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (m.running && m.tick == 6) found = 1'b1;
    end
    check("t6_reach_tick6", int'(found), 1);
    @(posedge clk);
    #2;
    check("t6_psen_before_reset", int'(PSEN), 0);
    reset = 1'b0;
    #1;
    check("t6_psen_after_reset", int'(PSEN), 1);
    check("t6_ale_after_reset", int'(ALE), 0);
    check("t6_state_after_reset", int'(state), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    $display("phase async-reset: done at %0t", $time);

    // Randomised run
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      reset     = ($urandom_range(0, 599) != 0);
      run       = ($urandom_range(0, 9) != 0);
      hold      = ($urandom_range(0, 3) == 0);
      ext_fetch = 1'($urandom_range(0, 1));
      cycles    = CYC_W'($urandom_range(0, 3));
    end
    @(posedge clk);
    #1 reset = 1'b1; hold = 1'b0;
    repeat (4) @(posedge clk);
    $display("phase random: done at %0t", $time);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
